change_dispenser: RTL and testbench

CHANGE_DISPENSER -- requirements
Module: change_dispenser

---
 rtl/change_dispenser_pkg.sv | 48 ++++
 rtl/dispense_timer.sv | 31 +++
 rtl/change_dispenser.sv | 156 +++++++++++++++
 tb/tb_change_dispenser.sv | 358 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser and its vending-FSM bench:
// state encoding, coin identities, coin unit values and the owed update rule.
package change_dispenser_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SELECT = 3'd1,
        ST_PULSE  = 3'd2,
        ST_GAP    = 3'd3,
        ST_FAULT  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        COIN_NONE = 2'd0,
        COIN_50   = 2'd1,
        COIN_100  = 2'd2,
        COIN_200  = 2'd3
    } coin_e;

    // Change is counted in units of 50.
    localparam logic [3:0] UNITS_50  = 4'd1;
    localparam logic [3:0] UNITS_100 = 4'd2;
    localparam logic [3:0] UNITS_200 = 4'd4;
    localparam logic [3:0] OWED_MAX  = 4'd15;

    function automatic logic [3:0] coin_units(input coin_e coin);
        case (coin)
            COIN_50:  return UNITS_50;
            COIN_100: return UNITS_100;
            COIN_200: return UNITS_200;
            default:  return 4'd0;
        endcase
    endfunction

    // owed + add - sub, clamped at OWED_MAX; sub never exceeds owed because a
    // coin is only selected when owed covers it.
    function automatic logic [3:0] owed_update(input logic [3:0] owed,
                                               input logic [3:0] add,
                                               input logic [3:0] sub);
        logic [4:0] sum;
        sum = {1'b0, owed} + {1'b0, add} - {1'b0, sub};
        if (sum > {1'b0, OWED_MAX}) begin
            return OWED_MAX;
        end
        return sum[3:0];
    endfunction

endpackage

// File: rtl/dispense_timer.sv
// Loadable down-counter shared by the ejector pulse and the post-pulse gap;
// o_tc flags the last cycle of the loaded interval.
module dispense_timer #(
    parameter  int MAX_COUNT = 2,
    localparam int W         = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_load,
    input  logic [W-1:0] i_load_val,
    output logic         o_tc
);

    logic [W-1:0] r_count;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the values from before the edge, independent of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - 1'b1;
        end
    end

    // Loading N-1 makes the interval last exactly N cycles.
    assign o_tc = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: accumulates change requests in units of 50 and pays them
// out greedily through three coin ejectors with timed pulses and gaps.
module change_dispenser
    import change_dispenser_pkg::*;
#(
    parameter int PULSE_CYCLES = 2,
    parameter int GAP_CYCLES   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       t50,
    input  logic       t100,
    input  logic       t200,
    input  logic       empty50,
    input  logic       empty100,
    input  logic       empty200,
    output logic       ej50,
    output logic       ej100,
    output logic       ej200,
    output logic       busy,
    output logic       fault,
    output logic [3:0] owed_o,
    output logic [2:0] state_o
);

    localparam int TMR_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
    localparam logic [TMR_W-1:0] PULSE_LOAD = TMR_W'(PULSE_CYCLES - 1);
    localparam logic [TMR_W-1:0] GAP_LOAD   = TMR_W'(GAP_CYCLES - 1);

    state_e     r_state;
    coin_e      r_coin;
    logic [3:0] r_owed;
    logic       r_t50_q;
    logic       r_t100_q;
    logic       r_t200_q;

    state_e           w_state_next;
    coin_e            w_coin_next;
    logic [3:0]       w_add;
    logic [3:0]       w_sub;
    logic             w_tmr_load;
    logic [TMR_W-1:0] w_tmr_val;
    logic             w_tmr_tc;
    logic             w_rise50;
    logic             w_rise100;
    logic             w_rise200;

    assign w_rise50  = t50  & ~r_t50_q;
    assign w_rise100 = t100 & ~r_t100_q;
    assign w_rise200 = t200 & ~r_t200_q;

    assign w_add = (w_rise50  ? UNITS_50  : 4'd0)
                 + (w_rise100 ? UNITS_100 : 4'd0)
                 + (w_rise200 ? UNITS_200 : 4'd0);

    dispense_timer #(
        .MAX_COUNT (TMR_MAX)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_tc       (w_tmr_tc)
    );

    // NOTE: reset is asynchronous, so the decoded ejector outputs fall the
    // moment rst rises, even in the middle of a pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_coin  <= COIN_NONE;
        end else begin
            r_state <= w_state_next;
            r_coin  <= w_coin_next;
        end
    end

    // Requests keep accumulating in every state, FAULT included.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_owed   <= '0;
            r_t50_q  <= 1'b0;
            r_t100_q <= 1'b0;
            r_t200_q <= 1'b0;
        end else begin
            r_owed   <= owed_update(r_owed, w_add, w_sub);
            r_t50_q  <= t50;
            r_t100_q <= t100;
            r_t200_q <= t200;
        end
    end

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        w_state_next = r_state;
        w_coin_next  = r_coin;
        w_sub        = 4'd0;
        w_tmr_load   = 1'b0;
        w_tmr_val    = '0;
        case (r_state)
            ST_IDLE: begin
                if (r_owed != 4'd0) begin
                    w_state_next = ST_SELECT;
                end
            end
            ST_SELECT: begin
                w_tmr_load   = 1'b1;
                w_tmr_val    = PULSE_LOAD;
                w_state_next = ST_PULSE;
                if (r_owed >= UNITS_200 && !empty200) begin
                    w_coin_next = COIN_200;
                end else if (r_owed >= UNITS_100 && !empty100) begin
                    w_coin_next = COIN_100;
                end else if (r_owed >= UNITS_50 && !empty50) begin
                    w_coin_next = COIN_50;
                end else begin
                    w_coin_next  = COIN_NONE;
                    w_tmr_load   = 1'b0;
                    w_state_next = ST_FAULT;
                end
            end
            ST_PULSE: begin
                if (w_tmr_tc) begin
                    w_sub        = coin_units(r_coin);
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = GAP_LOAD;
                    w_state_next = ST_GAP;
                end
            end
            ST_GAP: begin
                if (w_tmr_tc) begin
                    w_state_next = (r_owed == 4'd0) ? ST_IDLE : ST_SELECT;
                end
            end
            ST_FAULT: begin
                w_state_next = ST_FAULT;
            end
            default: begin
                w_state_next = ST_FAULT;
            end
        endcase
    end

    // Outputs decode registered state only; r_coin holds one coin, so at most
    // one ejector can be driven.
    assign ej50    = (r_state == ST_PULSE) && (r_coin == COIN_50);
    assign ej100   = (r_state == ST_PULSE) && (r_coin == COIN_100);
    assign ej200   = (r_state == ST_PULSE) && (r_coin == COIN_200);
    assign busy    = (r_state != ST_IDLE) || (r_owed != 4'd0);
    assign fault   = (r_state == ST_FAULT);
    assign owed_o  = r_owed;
    assign state_o = r_state;

endmodule

// File: tb/tb_change_dispenser.sv
// Scenario bench for change_dispenser: expected coin pulses are queued when a
// request is driven and matched by a pulse monitor as the ejectors fire.
module tb_change_dispenser;

    localparam int PULSE = 2;
    localparam int GAP   = 2;

    logic       clk;
    logic       rst;
    logic       t50, t100, t200;
    logic       empty50, empty100, empty200;
    logic       ej50, ej100, ej200;
    logic       busy, fault;
    logic [3:0] owed_o;
    logic [2:0] state_o;

    int n_tests = 0;
    int n_fail  = 0;

    int exp_q[$];
    int exp_coin;
    int mon_width   = 0;
    int mon_low_run = 0;
    int mon_hi;
    int mon_coin;
    int mon_cur     = 0;
    int last_gap    = -1;

    change_dispenser #(
        .PULSE_CYCLES (PULSE),
        .GAP_CYCLES   (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .t50      (t50),
        .t100     (t100),
        .t200     (t200),
        .empty50  (empty50),
        .empty100 (empty100),
        .empty200 (empty200),
        .ej50     (ej50),
        .ej100    (ej100),
        .ej200    (ej200),
        .busy     (busy),
        .fault    (fault),
        .owed_o   (owed_o),
        .state_o  (state_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse monitor: measures each ejector pulse and matches it to the queue.
    always @(negedge clk) begin
        if (rst) begin
            mon_width   = 0;
            mon_low_run = 0;
        end else begin
            mon_hi = int'(ej50) + int'(ej100) + int'(ej200);
            n_tests++;
            if (mon_hi > 1) begin
                n_fail++;
                $display("FAIL onehot: %0d ejectors high, required at most 1", mon_hi);
            end
            if (mon_hi != 0) begin
                mon_coin = ej200 ? 200 : (ej100 ? 100 : 50);
                if (mon_width == 0) begin
                    last_gap = mon_low_run;
                    mon_cur  = mon_coin;
                end else if (mon_coin != mon_cur) begin
                    n_fail++;
                    $display("FAIL pulse_coin_change: ej%0d replaced ej%0d mid-pulse", mon_coin, mon_cur);
                end
                mon_width++;
            end else if (mon_width != 0) begin
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL pulse_unexpected: got ej%0d width %0d, required no pulse", mon_cur, mon_width);
                end else begin
                    exp_coin = exp_q.pop_front();
                    if (mon_cur !== exp_coin || mon_width !== PULSE) begin
                        n_fail++;
                        $display("FAIL pulse_match: got ej%0d width %0d, required ej%0d width %0d",
                                 mon_cur, mon_width, exp_coin, PULSE);
                    end
                end
                mon_width   = 0;
                mon_low_run = 1;
            end else begin
                mon_low_run++;
            end
        end
    end

    // One request edge: inputs high for one clock, then low for one clock.
    task automatic pulse_req(input logic a50, input logic a100, input logic a200);
        t50  = a50;
        t100 = a100;
        t200 = a200;
        @(negedge clk);
        t50  = 1'b0;
        t100 = 1'b0;
        t200 = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 200) begin
            n_fail++;
            $display("FAIL %s_idle_timeout: busy=%0b pending=%0d after %0d cycles, required idle",
                     name, busy, exp_q.size(), n);
        end
        n_tests++;
        if ({fault, owed_o, state_o} !== 8'd0) begin
            n_fail++;
            $display("FAIL %s_idle_state: fault=%0b owed=%0d state=%0d, required 0/0/0",
                     name, fault, owed_o, state_o);
        end
    endtask

    task automatic wait_ej(input int coin, input string name);
        int n = 0;
        while (!((coin == 50 && ej50 === 1'b1) || (coin == 100 && ej100 === 1'b1) ||
                 (coin == 200 && ej200 === 1'b1)) && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_tests++;
        if (n >= 50) begin
            n_fail++;
            $display("FAIL %s_ej_timeout: ej%0d never rose, required a pulse", name, coin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        t50 = 1'b0; t100 = 1'b0; t200 = 1'b0;
        empty50 = 1'b0; empty100 = 1'b0; empty200 = 1'b0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({ej50, ej100, ej200, busy, fault} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags: ej=%b busy=%0b fault=%0b, required all 0",
                     {ej50, ej100, ej200}, busy, fault);
        end
        n_tests++;
        if (owed_o !== 4'd0 || state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_regs: owed=%0d state=%0d, required 0/0", owed_o, state_o);
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_tests++;
        if (busy !== 1'b0 || state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL reset_release: busy=%0b state=%0d, required 0/0", busy, state_o);
        end
    endtask

    task automatic test_single_50();
        exp_q.push_back(50);
        pulse_req(1'b1, 1'b0, 1'b0);
        n_tests++;
        if (owed_o !== 4'd1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single50_owed: owed=%0d busy=%0b, required 1/1", owed_o, busy);
        end
        wait_idle("single50");
    endtask

    task automatic test_combined_150();
        exp_q.push_back(100);
        exp_q.push_back(50);
        pulse_req(1'b1, 1'b1, 1'b0);
        n_tests++;
        if (owed_o !== 4'd3) begin
            n_fail++;
            $display("FAIL combined150_owed: owed=%0d, required 3", owed_o);
        end
        wait_idle("combined150");
    endtask

    task automatic test_empty100();
        empty100 = 1'b1;
        last_gap = -1;
        exp_q.push_back(50);
        exp_q.push_back(50);
        pulse_req(1'b0, 1'b1, 1'b0);
        n_tests++;
        if (owed_o !== 4'd2) begin
            n_fail++;
            $display("FAIL empty100_owed: owed=%0d, required 2", owed_o);
        end
        wait_idle("empty100");
        // Ejectors stay low through the gap plus the one-cycle SELECT.
        n_tests++;
        if (last_gap !== GAP + 1) begin
            n_fail++;
            $display("FAIL empty100_gap: low cycles between pulses=%0d, required %0d", last_gap, GAP + 1);
        end
        empty100 = 1'b0;
    endtask

    task automatic test_add_during_pulse();
        exp_q.push_back(100);
        pulse_req(1'b0, 1'b1, 1'b0);
        wait_ej(100, "addpulse");
        @(negedge clk);
        // Last PULSE cycle: the new request lands together with the subtraction.
        exp_q.push_back(50);
        t50 = 1'b1;
        @(negedge clk);
        t50 = 1'b0;
        n_tests++;
        if (owed_o !== 4'd1 || state_o !== 3'd3) begin
            n_fail++;
            $display("FAIL addpulse_owed: owed=%0d state=%0d, required 1/3", owed_o, state_o);
        end
        wait_idle("addpulse");
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(200);
        exp_q.push_back(50);
        pulse_req(1'b1, 1'b0, 1'b1);
        n_tests++;
        if (owed_o !== 4'd5) begin
            n_fail++;
            $display("FAIL b2b_owed: owed=%0d, required 5", owed_o);
        end
        wait_idle("b2b_250");
        exp_q.push_back(100);
        pulse_req(1'b0, 1'b1, 1'b0);
        wait_idle("b2b_100");
    endtask

    task automatic test_fault();
        int model = 1;
        empty50 = 1'b1;
        pulse_req(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        n_tests++;
        if (state_o !== 3'd4 || fault !== 1'b1) begin
            n_fail++;
            $display("FAIL fault_enter: state=%0d fault=%0b, required 4/1", state_o, fault);
        end
        empty50 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_tests++;
            if ({ej50, ej100, ej200} !== 3'b0 || owed_o !== 4'd1 || state_o !== 3'd4) begin
                n_fail++;
                $display("FAIL fault_hold: ej=%b owed=%0d state=%0d, required 000/1/4",
                         {ej50, ej100, ej200}, owed_o, state_o);
            end
        end
        // Requests still accumulate in FAULT and saturate at 15.
        for (int i = 0; i < 4; i++) begin
            pulse_req(1'b0, 1'b0, 1'b1);
            model = (model + 4 > 15) ? 15 : model + 4;
            n_tests++;
            if (owed_o !== 4'(model)) begin
                n_fail++;
                $display("FAIL fault_accum: owed=%0d, required %0d", owed_o, model);
            end
        end
        pulse_req(1'b1, 1'b1, 1'b1);
        n_tests++;
        if (owed_o !== 4'd15 || state_o !== 3'd4) begin
            n_fail++;
            $display("FAIL fault_saturate: owed=%0d state=%0d, required 15/4", owed_o, state_o);
        end
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({fault, owed_o, state_o} !== 8'd0) begin
            n_fail++;
            $display("FAIL fault_clear: fault=%0b owed=%0d state=%0d, required 0/0/0",
                     fault, owed_o, state_o);
        end
    endtask

    task automatic test_reset_mid_pulse();
        exp_q.push_back(200);
        pulse_req(1'b0, 1'b0, 1'b1);
        wait_ej(200, "rstpulse");
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({ej50, ej100, ej200, busy} !== 4'b0 || owed_o !== 4'd0 || state_o !== 3'd0) begin
            n_fail++;
            $display("FAIL rstpulse_async: ej=%b busy=%0b owed=%0d state=%0d, required all 0",
                     {ej50, ej100, ej200}, busy, owed_o, state_o);
        end
        @(negedge clk);
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        exp_q.push_back(100);
        pulse_req(1'b0, 1'b1, 1'b0);
        wait_idle("rstpulse_after");
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1;
        t50 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        exp_q.push_back(50);
        rst = 1'b0;
        @(negedge clk);
        n_tests++;
        if (owed_o !== 4'd1) begin
            n_fail++;
            $display("FAIL held_edge: owed=%0d, required 1", owed_o);
        end
        wait_idle("held");
        t50 = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        test_reset();
        test_single_50();
        test_combined_150();
        test_empty100();
        test_add_during_pulse();
        test_back_to_back();
        test_fault();
        test_reset_mid_pulse();
        test_held_through_reset();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover_pulses: %0d expected pulses never seen, required 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
